// File: rtl/lmmi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lmmi_rr_arbiter
// Purpose  : Round-robin arbiter that lets NUM_REQ valid/ack requesters share
//            a single LMMI target port, one access in flight at a time. Reads
//            that never return data are closed by a watchdog with an error.
// Ports    : clk, rst_n               clock, synchronous active-low reset
//            req_valid_i/we_i         per-requester request and direction
//            req_offset_i/wdata_i     packed per-requester offset / write data
//            req_ack_o/err_o          one-hot completion / timeout-error pulse
//            req_rdata_o              read data, non-zero only during ack
//            lmmi_*                   LMMI target-side port
//            busy_o, grant_id_o       status: not idle / current-last grant
// Revision : 1.0 - initial release
// ============================================================================
module lmmi_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0]      req_we_i,
  input  logic [16*NUM_REQ-1:0]   req_offset_i,
  input  logic [32*NUM_REQ-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]      req_ack_o,
  output logic [NUM_REQ-1:0]      req_err_o,
  output logic [31:0]             req_rdata_o,
  output logic                    lmmi_request_o,
  output logic                    lmmi_wr_rdn_o,
  output logic [15:0]             lmmi_offset_o,
  output logic [31:0]             lmmi_wdata_o,
  input  logic                    lmmi_ready_i,
  input  logic [31:0]             lmmi_rdata_i,
  input  logic                    lmmi_rdata_valid_i,
  output logic                    busy_o,
  output logic [2:0]              grant_id_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam int         CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       gid_q, gid_d;
  logic             we_q, we_d;
  logic [15:0]      off_q, off_d;
  logic [31:0]      wd_q, wd_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_found;
  logic [2:0]       win_idx;
  logic [7:0]       valid_ext;
  logic             sel_we;
  logic [15:0]      sel_off;
  logic [31:0]      sel_wd;
  logic             wdog_expire;

  // Zero-extend to 8 bits so a 3-bit candidate index is always in range.
  assign valid_ext = 8'(req_valid_i);

  // Rotating priority: the search starts one past the last winner and wraps.
  always_comb begin
    logic [2:0] cand;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 3'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && valid_ext[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Mux the winner's request fields out of the packed input buses.
  always_comb begin
    sel_we  = 1'b0;
    sel_off = 16'd0;
    sel_wd  = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        sel_we  = req_we_i[i];
        sel_off = req_offset_i[16*i +: 16];
        sel_wd  = req_wdata_i[32*i +: 32];
      end
    end
  end

  // The counter value seen in the current WAIT_RD cycle is one behind the
  // number of WAIT_RD cycles spent, so expiry triggers at TIMEOUT-1.
  generate
    if (TIMEOUT == 0) begin : g_wdog_off
      assign wdog_expire = 1'b0;
    end else begin : g_wdog_on
      assign wdog_expire = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    we_d    = we_q;
    off_d   = off_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          last_d  = win_idx;
          gid_d   = win_idx;
          we_d    = sel_we;
          off_d   = sel_off;
          wd_d    = sel_wd;
          rdata_d = 32'd0;   // writes answer with zero data
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (lmmi_ready_i) begin
          if (we_q) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        // Valid data takes precedence over a simultaneous expiry.
        if (lmmi_rdata_valid_i) begin
          rdata_d = lmmi_rdata_i;
          state_d = S_RESP;
        end else if (wdog_expire) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      gid_q   <= 3'd0;
      we_q    <= 1'b0;
      off_q   <= 16'd0;
      wd_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      we_q    <= we_d;
      off_q   <= off_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
      assign req_ack_o[i] = (state_q == S_RESP) && (gid_q == 3'(i));
      assign req_err_o[i] = (state_q == S_RESP) && (gid_q == 3'(i)) && err_q;
    end
  endgenerate

  assign req_rdata_o    = (state_q == S_RESP) ? rdata_q : 32'd0;
  assign lmmi_request_o = (state_q == S_ISSUE);
  assign lmmi_wr_rdn_o  = we_q;
  assign lmmi_offset_o  = off_q;
  assign lmmi_wdata_o   = wd_q;
  assign busy_o         = (state_q != S_IDLE);
  assign grant_id_o     = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_lmmi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lmmi_rr_arbiter
// Purpose  : Self-checking bench for lmmi_rr_arbiter. A transaction-level
//            reference model predicts grants (round-robin over the requesting
//            set), acceptance times and completion times from the LMMI
//            handshake it drives, and every cycle compares all DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lmmi_rr_arbiter;

  localparam int NR = 2;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_we, req_ack, req_err;
  logic [16*NR-1:0]  req_offset;
  logic [32*NR-1:0]  req_wdata;
  logic [31:0]       req_rdata, lmmi_wdata, lmmi_rdata;
  logic              lmmi_request, lmmi_wr_rdn, lmmi_ready, lmmi_rdata_valid, busy;
  logic [15:0]       lmmi_offset;
  logic [2:0]        grant_id;

  lmmi_rr_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid_i        (req_valid),
    .req_we_i           (req_we),
    .req_offset_i       (req_offset),
    .req_wdata_i        (req_wdata),
    .req_ack_o          (req_ack),
    .req_err_o          (req_err),
    .req_rdata_o        (req_rdata),
    .lmmi_request_o     (lmmi_request),
    .lmmi_wr_rdn_o      (lmmi_wr_rdn),
    .lmmi_offset_o      (lmmi_offset),
    .lmmi_wdata_o       (lmmi_wdata),
    .lmmi_ready_i       (lmmi_ready),
    .lmmi_rdata_i       (lmmi_rdata),
    .lmmi_rdata_valid_i (lmmi_rdata_valid),
    .busy_o             (busy),
    .grant_id_o         (grant_id)
  );

  always #5 clk = ~clk;

  // k = cycles from accept to rdata_valid; k > TO means the target never answers.
  typedef struct {
    int        id;
    bit        we;
    bit [15:0] off;
    bit [31:0] wd;
    int        k;
    bit [31:0] rd;
  } txn_t;

  txn_t pend[$];
  txn_t cur[NR];
  bit   hold[NR];
  txn_t mt;
  bit   m_act;
  int   m_g, m_a, m_ack, m_last, m_next;
  bit [15:0] e_off;
  bit [31:0] e_wd;
  bit        e_we;
  bit [2:0]  e_gid;
  int   n, total, bad;
  bit   rdy_prev, rdy_always, rand_en, stray_en, late_rv;
  int   rdy_hold;
  int   dut_order[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", tag, n, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int lst);
    for (int d = 1; d <= NR; d++)
      if (v[(lst + d) % NR]) return (lst + d) % NR;
    return -1;
  endfunction

  function automatic txn_t mk(input int id, input bit we, input bit [15:0] off,
                              input bit [31:0] wd, input int k, input bit [31:0] rd);
    txn_t t;
    t.id = id; t.we = we; t.off = off; t.wd = wd; t.k = k; t.rd = rd;
    return t;
  endfunction

  function automatic txn_t rand_txn(input int id);
    return mk(id, bit'($urandom_range(0, 1)), 16'($urandom), $urandom,
              $urandom_range(1, TO + 3), $urandom);
  endfunction

  // One clock: observe/check at the falling edge, then drive the next inputs.
  task automatic step(input bit rst_next);
    logic [NR-1:0] e_ack, e_err;
    logic [31:0]   e_rd;
    bit            e_req, e_busy;
    int            w;
    @(negedge clk);
    n++;
    e_ack = '0; e_err = '0; e_rd = 32'd0; e_req = 1'b0; e_busy = 1'b0;
    for (int i = 0; i < NR; i++) hold[i] = 1'b0;
    if (!rst_n) begin
      m_act = 1'b0; m_last = NR - 1; m_next = n + 1;
      e_off = '0; e_wd = '0; e_we = 1'b0; e_gid = '0;
      req_valid = '0;
    end else begin
      if (m_act && m_a < 0 && n - 1 >= m_g && rdy_prev) begin
        m_a = n;
        if (mt.we)           m_ack = n;
        else if (mt.k <= TO) m_ack = n + mt.k;
        else                 m_ack = n + TO;
      end
      e_req  = m_act && m_a < 0 && n >= m_g;
      e_busy = m_act && n >= m_g;
      if (m_act && n == m_ack) begin
        e_ack[mt.id] = 1'b1;
        if (!mt.we && mt.k > TO)  e_err[mt.id] = 1'b1;
        if (!mt.we && mt.k <= TO) e_rd = mt.rd;
      end
    end
    check_eq("req_ack",      32'(req_ack),      32'(e_ack));
    check_eq("req_err",      32'(req_err),      32'(e_err));
    check_eq("req_rdata",    req_rdata,         e_rd);
    check_eq("lmmi_request", 32'(lmmi_request), 32'(e_req));
    check_eq("busy",         32'(busy),         32'(e_busy));
    check_eq("grant_id",     32'(grant_id),     32'(e_gid));
    check_eq("lmmi_offset",  32'(lmmi_offset),  32'(e_off));
    check_eq("lmmi_wdata",   lmmi_wdata,        e_wd);
    check_eq("lmmi_wr_rdn",  32'(lmmi_wr_rdn),  32'(e_we));
    if (rst_n && m_act && n == m_g) dut_order.push_back(int'(grant_id));
    if (rst_n && m_act && n == m_ack) begin
      m_act = 1'b0;
      req_valid[mt.id] = 1'b0;   // drop at the edge that samples the ack
      hold[mt.id] = 1'b1;
      m_next = n + 2;            // RESP is followed by one IDLE cycle
    end

    rst_n = rst_next;
    if (rand_en && pend.size() < 4) pend.push_back(rand_txn($urandom_range(0, NR - 1)));
    for (int i = 0; i < NR; i++) begin
      if (rst_next && !req_valid[i] && !hold[i]) begin
        for (int j = 0; j < pend.size(); j++) begin
          if (pend[j].id == i) begin
            cur[i] = pend[j];
            pend.delete(j);
            req_valid[i] = 1'b1;
            req_we[i] = cur[i].we;
            req_offset[16*i +: 16] = cur[i].off;
            req_wdata[32*i +: 32] = cur[i].wd;
            break;
          end
        end
      end
    end
    if (rst_next && !m_act && n + 1 >= m_next && |req_valid) begin
      w = rr_pick(req_valid, m_last);
      mt = cur[w]; m_act = 1'b1; m_g = n + 1; m_a = -1; m_ack = -1; m_last = w;
      e_off = mt.off; e_wd = mt.wd; e_we = mt.we; e_gid = 3'(w);
    end
    if (rdy_hold > 0) begin
      lmmi_ready = 1'b0;
      rdy_hold--;
    end else begin
      lmmi_ready = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    rdy_prev = lmmi_ready;
    lmmi_rdata_valid = 1'b0;
    lmmi_rdata = $urandom;
    if (m_act && m_a >= 0 && !mt.we && mt.k <= TO && n + 1 == m_a + mt.k) begin
      lmmi_rdata_valid = 1'b1;
      lmmi_rdata = mt.rd;
    end else if (late_rv) begin
      lmmi_rdata_valid = 1'b1;
      late_rv = 1'b0;
    end else if (stray_en && $urandom_range(0, 3) == 0 &&
                 !(m_act && m_a >= 0 && !mt.we && n + 1 <= m_a + TO)) begin
      lmmi_rdata_valid = 1'b1;   // stray strobe outside the read window
    end
  endtask

  task automatic drain(input int maxc);
    int c;
    bit done;
    c = 0;
    while ((m_act || pend.size() != 0 || |req_valid) && c < maxc) begin
      step(1'b1);
      c++;
    end
    done = !(m_act || pend.size() != 0 || |req_valid);
    check_eq("drain_done", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    step(1'b0); step(1'b0); step(1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at cycle %0d", n);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int t0, c;
    n = 0; total = 0; bad = 0; rdy_hold = 0; rdy_always = 1'b0;
    rand_en = 1'b0; stray_en = 1'b0; late_rv = 1'b0; rdy_prev = 1'b0;
    m_act = 1'b0; m_last = NR - 1; m_next = 0; m_g = 0; m_a = -1; m_ack = -1;
    e_off = '0; e_wd = '0; e_we = 1'b0; e_gid = '0;
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_offset = '0; req_wdata = '0;
    lmmi_ready = 1'b0; lmmi_rdata = '0; lmmi_rdata_valid = 1'b0;
    do_reset();

    // 1: single write, target always ready; ack in the third cycle of valid.
    rdy_always = 1'b1;
    pend.push_back(mk(0, 1'b1, 16'h0010, 32'hA5A5_0001, 0, 0));
    step(1'b1);
    t0 = n;
    c = 0;
    while (!req_ack[0] && c < 10) begin step(1'b1); c++; end
    check_eq("t1_ack_latency", 32'(n - t0), 32'd2);
    drain(50);

    // 2: read from requester 1, data two cycles after accept.
    pend.push_back(mk(1, 1'b0, 16'h0004, 32'h0, 2, 32'h1234_5678));
    drain(50);
    rdy_always = 1'b0;

    // 3: both requesters continuously reading -> strict alternation from 0.
    do_reset();
    dut_order.delete();
    for (int i = 0; i < 6; i++)
      pend.push_back(mk(i % 2, 1'b0, 16'(16'h100 + i), $urandom, $urandom_range(1, 4), $urandom));
    drain(300);
    check_eq("t3_grant_count", 32'(dut_order.size()), 32'd6);
    for (int i = 0; i < dut_order.size(); i++)
      check_eq("t3_grant_order", 32'(dut_order[i]), 32'(i % 2));

    // 4: unanswered read times out; then data arriving on the expiry cycle wins.
    pend.push_back(mk(0, 1'b0, 16'h0020, 32'h0, TO + 5, 32'hDEAD_BEEF));
    drain(100);
    pend.push_back(mk(1, 1'b0, 16'h0024, 32'h0, TO, 32'hCAFE_0008));
    drain(100);

    // 5: target stalls in ISSUE, request and address must hold.
    rdy_hold = 22;
    pend.push_back(mk(1, 1'b1, 16'h0030, 32'h5555_AAAA, 0, 0));
    drain(100);

    // 6: reset during WAIT_RD, late rdata_valid, then arbitration restarts at 0.
    pend.push_back(mk(1, 1'b0, 16'h0040, 32'h0, TO + 5, 32'h0));
    c = 0;
    while (!(m_act && m_a >= 0) && c < 50) begin step(1'b1); c++; end
    check_eq("t6_reached_wait", 32'(m_act && m_a >= 0), 32'd1);
    step(1'b1); step(1'b1);
    step(1'b0); step(1'b0);
    late_rv = 1'b1;
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1);
    dut_order.delete();
    pend.push_back(mk(1, 1'b1, 16'h0050, $urandom, 0, 0));
    pend.push_back(mk(0, 1'b1, 16'h0054, $urandom, 0, 0));
    drain(100);
    check_eq("t6_first_grant", 32'(dut_order.size() > 0 ? dut_order[0] : -1), 32'd0);

    // Random traffic with random ready, latencies, timeouts and stray strobes.
    rand_en = 1'b1;
    stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) step(1'b1);
    rand_en = 1'b0;
    drain(500);
    stray_en = 1'b0;
    step(1'b1); step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
